login_reply_tx: RTL

LOGIN_REPLY_TX -- requirements
Module: login_reply_tx

---
 rtl/login_pkg.sv | 80 ++++++++
 rtl/login_reply_tx_uart_tx_core.sv | 98 +++++++++
 rtl/login_reply_tx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/login_pkg.sv
// -----------------------------------------------------------------------------
// login_pkg
// Shared definitions for the login reply transmitter: FSM state encoding,
// message byte constants, message lengths and small helper functions.
//
// Configuration macro: LOGIN_REPLY_CRLF_EN
//   When defined, every reply is terminated with CR LF (0x0D 0x0A), so
//   "OK" is 4 bytes and "FAIL" is 6 bytes. When undefined no terminator
//   bytes exist anywhere in the design.
// -----------------------------------------------------------------------------
package login_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BYTE = 2'd2,
    FINISH    = 2'd3
  } state_t;

  localparam logic [7:0] CH_O = 8'h4F;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_F = 8'h46;
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_L = 8'h4C;

`ifdef LOGIN_REPLY_CRLF_EN
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [2:0] OK_LEN   = 3'd4;
  localparam logic [2:0] FAIL_LEN = 3'd6;
`else
  localparam logic [2:0] OK_LEN   = 3'd2;
  localparam logic [2:0] FAIL_LEN = 3'd4;
`endif

  // Byte idx of the selected reply; out-of-range indices return idle-line 0xFF.
  function automatic logic [7:0] msg_byte(input logic is_fail, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'hFF;
    if (is_fail) begin
      case (idx)
        3'd0:    b = CH_F;
        3'd1:    b = CH_A;
        3'd2:    b = CH_I;
        3'd3:    b = CH_L;
`ifdef LOGIN_REPLY_CRLF_EN
        3'd4:    b = CH_CR;
        3'd5:    b = CH_LF;
`endif
        default: b = 8'hFF;
      endcase
    end else begin
      case (idx)
        3'd0:    b = CH_O;
        3'd1:    b = CH_K;
`ifdef LOGIN_REPLY_CRLF_EN
        3'd2:    b = CH_CR;
        3'd3:    b = CH_LF;
`endif
        default: b = 8'hFF;
      endcase
    end
    return b;
  endfunction

  // Line level for position idx of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic [3:0] j;
    j = idx - 4'd1;
    if (idx == 4'd0) begin
      return 1'b0;
    end else if (idx >= 4'd9) begin
      return 1'b1;
    end else begin
      return data[j[2:0]];
    end
  endfunction

endpackage

// File: rtl/login_reply_tx_uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// 8N1 UART serialiser. A start request is accepted when idle or on the very
// edge that ends the current stop bit, which lets a caller chain bytes with
// no idle gap.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      request to send data (sampled on the rising edge)
//   data[7:0]  byte to send, captured with start
//   tx         serial line (idles high), registered
//   busy       frame in progress, registered
//   done       one-cycle pulse in the second-to-last cycle of the stop bit,
//              early enough for a registered caller to chain the next byte
// Parameter:
//   CLKS_PER_BIT  clock cycles per bit (minimum 2)
// -----------------------------------------------------------------------------
module uart_tx_core
  import login_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_NEAR = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [3:0]    bit_idx;
  logic [3:0]    bit_n;
  logic [7:0]    shadow;
  logic [7:0]    shadow_n;
  logic          active_n;
  logic          bit_end;
  logic          frame_end;
  logic          load;

  // Next-state of the frame position; tx and done are derived from it so both stay registered.
  always_comb begin
    bit_end   = (cnt == CNT_LAST);
    frame_end = busy && bit_end && (bit_idx == 4'd9);
    load      = start && (!busy || frame_end);
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shadow_n  = shadow;
    active_n  = busy;
    if (load) begin
      active_n = 1'b1;
      cnt_n    = '0;
      bit_n    = 4'd0;
      shadow_n = data;
    end else if (busy) begin
      if (bit_end) begin
        cnt_n = '0;
        if (bit_idx == 4'd9) begin
          active_n = 1'b0;
          bit_n    = 4'd0;
        end else begin
          bit_n = bit_idx + 4'd1;
        end
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end else begin
      cnt_n = '0;
      bit_n = 4'd0;
    end
  end

  // Frame state and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      bit_idx <= 4'd0;
      shadow  <= 8'h00;
    end else begin
      busy    <= active_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shadow  <= shadow_n;
      tx      <= active_n ? frame_bit(shadow_n, bit_n) : 1'b1;
      done    <= active_n && (bit_n == 4'd9) && (cnt_n == CNT_NEAR);
    end
  end

endmodule

// File: rtl/login_reply_tx.sv
// -----------------------------------------------------------------------------
// login_reply_tx
// Sends "OK" on a rising edge of login_success and "FAIL" on a rising edge of
// login_fail (fail wins if both rise together) over an 8N1 UART line.
// Events arriving while a reply is in progress are dropped, not queued.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   login_success  level, rising edge requests "OK"
//   login_fail     level, rising edge requests "FAIL"
//   tx             UART line, idles high
//   busy           high while a reply is in progress
//   done           one-cycle pulse when the last stop bit completes
// Parameter:
//   CLKS_PER_BIT   clock cycles per UART bit (minimum 2)
// Configuration macro: LOGIN_REPLY_CRLF_EN appends CR LF to each reply.
// -----------------------------------------------------------------------------
module login_reply_tx
  import login_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic login_success,
  input  logic login_fail,
  output logic tx,
  output logic busy,
  output logic done
);

  state_t     state;
  logic [2:0] idx;
  logic       is_fail;
  logic       prev_s;
  logic       prev_f;
  logic       armed;
  logic       evt_s;
  logic       evt_f;
  logic       start;
  logic [7:0] data;
  logic [2:0] msg_len;
  logic       core_busy;
  logic       core_done;

  assign start   = (state == LOAD);
  assign data    = msg_byte(is_fail, idx);
  assign msg_len = is_fail ? FAIL_LEN : OK_LEN;

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (data),
    .tx   (tx),
    .busy (core_busy),
    .done (core_done)
  );

  // Edge detection plus reply sequencing FSM with registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 3'd0;
      is_fail <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prev_s  <= 1'b0;
      prev_f  <= 1'b0;
      armed   <= 1'b0;
      evt_s   <= 1'b0;
      evt_f   <= 1'b0;
    end else begin
      prev_s <= login_success;
      prev_f <= login_fail;
      // armed stays low for the first edge after reset so a level already
      // high at release is not mistaken for a rising edge.
      armed  <= 1'b1;
      // Edges are only captured while idle; anything else is dropped.
      evt_s  <= armed && (state == IDLE) && login_success && !prev_s;
      evt_f  <= armed && (state == IDLE) && login_fail && !prev_f;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          idx <= 3'd0;
          if ((evt_s || evt_f) && !core_busy) begin
            is_fail <= evt_f;
            state   <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          busy  <= 1'b1;
          state <= WAIT_BYTE;
        end
        WAIT_BYTE: begin
          // core_done arrives two cycles before the stop bit ends, so LOAD
          // presents the next byte exactly on the frame boundary.
          if (core_done) begin
            idx <= idx + 3'd1;
            if ((idx + 3'd1) == msg_len) begin
              state <= FINISH;
            end else begin
              state <= LOAD;
            end
          end else begin
            state <= WAIT_BYTE;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
